ospfb_input_pacer: RTL and testbench

- Sits between a sample source (impulse/counter generators, ADC capture) and the OSPFB polyphase front end.
- Enforces the oversampled cadence: exactly PAUSE (D) new samples are delivered per MAX_CNT (M) slot frame. The remaining M-D slots carry no new data.
- Absorbs upstream handshake jitter with a 2-entry skid buffer.
- Exports the modtimer phase and an underflow indication so the PFB and benches can align frames.

---
 rtl/ospfb_input_pacer.sv | 134 +++++++++++++
 tb/tb_ospfb_input_pacer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_input_pacer.sv
// ospfb_input_pacer
// Paces an upstream sample stream into the OSPFB polyphase front end. A slot
// counter (modtimer) walks 0..MAX_CNT-1 on every cycle the downstream is ready.
// Only the first PAUSE slots of each frame carry data. A 2-entry skid buffer
// absorbs upstream jitter. Starved pass slots are still consumed so the frame
// cadence never slips; they are flagged and counted instead.
module ospfb_input_pacer #(
  parameter int WIDTH   = 16,
  parameter int MAX_CNT = 64,
  parameter int PAUSE   = 48,
  parameter int START   = 47
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           s_axis_tdata_i,
  input  logic                       s_axis_tvalid_i,
  output logic                       s_axis_tready_o,
  output logic [WIDTH-1:0]           m_axis_tdata_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic                       m_axis_tlast_o,
  output logic [$clog2(MAX_CNT)-1:0] modtimer_o,
  output logic                       underflow_o,
  output logic [15:0]                underflow_cnt_o
);

  localparam int TW  = $clog2(MAX_CNT);
  localparam int TW1 = TW + 1;

  // One extra bit so PAUSE == MAX_CNT (no pause window) compares correctly.
  localparam logic [TW1-1:0] PAUSE_X    = TW1'(PAUSE);
  localparam logic [TW-1:0]  LAST_SLOT  = TW'(MAX_CNT - 1);
  localparam logic [TW-1:0]  START_SLOT = TW'(START);
  localparam logic [TW-1:0]  TLAST_SLOT = TW'(PAUSE - 1);

  logic [TW-1:0]    mt_q, mt_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic             uf_q, uf_d;
  logic [15:0]      ucnt_q, ucnt_d;

  logic in_pass;
  logic slot;
  logic push;
  logic pop;
  logic starve;

  // Handshake and window decode. Both ready/valid come from registered state
  // only (plus reset gating), so there is no combinational path s_axis -> m_axis.
  assign in_pass         = {1'b0, mt_q} < PAUSE_X;
  assign slot            = m_axis_tready_i && !rst;
  assign m_axis_tvalid_o = !rst && in_pass && (occ_q != 2'd0);
  assign m_axis_tlast_o  = m_axis_tvalid_o && (mt_q == TLAST_SLOT);
  assign s_axis_tready_o = !rst && (occ_q != 2'd2);
  assign m_axis_tdata_o  = buf_q[0];
  assign modtimer_o      = mt_q;
  assign underflow_o     = uf_q;
  assign underflow_cnt_o = ucnt_q;

  assign push   = s_axis_tvalid_i && s_axis_tready_o;
  assign pop    = m_axis_tvalid_o && m_axis_tready_i;
  assign starve = slot && in_pass && (occ_q == 2'd0);

  // Slot counter and starvation bookkeeping advance only on slots.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    mt_d   = mt_q;
    uf_d   = uf_q;
    ucnt_d = ucnt_q;
    if (slot) begin
      mt_d = (mt_q == LAST_SLOT) ? '0 : mt_q + TW'(1);
      if (starve) begin
        uf_d   = 1'b1;
        ucnt_d = (ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 16'd1;
      end
    end
  end

  // Skid buffer next state: FIFO order, push lands behind any existing entry.
  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    occ_d    = occ_q;
    unique case ({push, pop})
      2'b10: begin
        buf_d[occ_q[0]] = s_axis_tdata_i;
        occ_d           = occ_q + 2'd1;
      end
      2'b01: begin
        // With a single entry the head is left as is, so tdata holds its last
        // value through the pause window instead of showing a stale entry 1.
        if (occ_q == 2'd2) begin
          buf_d[0] = buf_q[1];
        end
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with one entry (tready is low when full): the new
        // sample replaces the popped head.
        buf_d[0] = s_axis_tdata_i;
      end
      default: begin
      end
    endcase
  end

  // Control state: reset restarts the frame at START with an empty buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      mt_q   <= START_SLOT;
      occ_q  <= 2'd0;
      uf_q   <= 1'b0;
      ucnt_q <= 16'd0;
    end else begin
      mt_q   <= mt_d;
      occ_q  <= occ_d;
      uf_q   <= uf_d;
      ucnt_q <= ucnt_d;
    end
  end

  // Sample storage.
  always_ff @(posedge clk) begin
    // NOTE: the data entries are deliberately not reset; occupancy alone
    // decides whether they are meaningful, and tvalid masks them while empty.
    buf_q[0] <= buf_d[0];
    buf_q[1] <= buf_d[1];
  end

endmodule

// File: tb/tb_ospfb_input_pacer.sv
// Directed bench for ospfb_input_pacer: default geometry (instance a) plus the
// two edge geometries MAX_CNT=16/PAUSE=16 (b) and MAX_CNT=16/PAUSE=12/START=11 (c).
// Each instance has an incrementing-counter source and a next-expected-sample
// scoreboard that checks every popped word for order and continuity.
module tb_ospfb_input_pacer;

  logic clk;
  logic rst;

  // Instance a: defaults (64 / 48 / 47)
  logic [15:0] a_s_data, a_m_data;
  logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_last, a_uf;
  logic [5:0]  a_mt;
  logic [15:0] a_ufc;

  // Instance b: 16 / 16 / 0
  logic [15:0] b_s_data, b_m_data;
  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last, b_uf;
  logic [3:0]  b_mt;
  logic [15:0] b_ufc;

  // Instance c: 16 / 12 / 11
  logic [15:0] c_s_data, c_m_data;
  logic        c_s_valid, c_s_ready, c_m_valid, c_m_ready, c_m_last, c_uf;
  logic [3:0]  c_mt;
  logic [15:0] c_ufc;

  // Source counters, scoreboards and per-edge handshake records
  logic [15:0] a_src, b_src, c_src;
  logic [15:0] a_exp, b_exp, c_exp;
  logic        a_acc, b_acc, c_acc;

  int n_checks;
  int n_fail;
  int exp_a, exp_b, exp_c;

  ospfb_input_pacer u_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata_i(a_s_data), .s_axis_tvalid_i(a_s_valid), .s_axis_tready_o(a_s_ready),
    .m_axis_tdata_o(a_m_data), .m_axis_tvalid_o(a_m_valid), .m_axis_tready_i(a_m_ready),
    .m_axis_tlast_o(a_m_last), .modtimer_o(a_mt), .underflow_o(a_uf), .underflow_cnt_o(a_ufc)
  );

  ospfb_input_pacer #(.WIDTH(16), .MAX_CNT(16), .PAUSE(16), .START(0)) u_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata_i(b_s_data), .s_axis_tvalid_i(b_s_valid), .s_axis_tready_o(b_s_ready),
    .m_axis_tdata_o(b_m_data), .m_axis_tvalid_o(b_m_valid), .m_axis_tready_i(b_m_ready),
    .m_axis_tlast_o(b_m_last), .modtimer_o(b_mt), .underflow_o(b_uf), .underflow_cnt_o(b_ufc)
  );

  ospfb_input_pacer #(.WIDTH(16), .MAX_CNT(16), .PAUSE(12), .START(11)) u_c (
    .clk(clk), .rst(rst),
    .s_axis_tdata_i(c_s_data), .s_axis_tvalid_i(c_s_valid), .s_axis_tready_o(c_s_ready),
    .m_axis_tdata_o(c_m_data), .m_axis_tvalid_o(c_m_valid), .m_axis_tready_i(c_m_ready),
    .m_axis_tlast_o(c_m_last), .modtimer_o(c_mt), .underflow_o(c_uf), .underflow_cnt_o(c_ufc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: record handshakes just before the edge, check popped words
  // against the scoreboards, then advance the sources after the edge.
  task automatic tick();
    #1;
    a_acc = a_s_valid && a_s_ready;
    b_acc = b_s_valid && b_s_ready;
    c_acc = c_s_valid && c_s_ready;
    if (a_m_valid && a_m_ready) begin
      check("a_pop_data", a_m_data, a_exp);
      a_exp++;
    end
    if (b_m_valid && b_m_ready) begin
      check("b_pop_data", b_m_data, b_exp);
      b_exp++;
    end
    if (c_m_valid && c_m_ready) begin
      check("c_pop_data", c_m_data, c_exp);
      c_exp++;
    end
    @(posedge clk);
    #1;
    if (a_acc) a_src++;
    if (b_acc) b_src++;
    if (c_acc) c_src++;
    a_s_data = a_src;
    b_s_data = b_src;
    c_s_data = c_src;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    a_src = '0; b_src = '0; c_src = '0;
    a_exp = '0; b_exp = '0; c_exp = '0;
    a_s_data = '0; b_s_data = '0; c_s_data = '0;
    a_s_valid = 1'b1; b_s_valid = 1'b1; c_s_valid = 1'b1;
    a_m_ready = 1'b1; b_m_ready = 1'b1; c_m_ready = 1'b1;
    rst = 1'b1;

    // ---- Reset: outputs gated while rst is high, state at START ----
    tick();
    tick();
    check("rst_a_tvalid", a_m_valid, 0);
    check("rst_a_tlast", a_m_last, 0);
    check("rst_a_s_tready", a_s_ready, 0);
    check("rst_b_tvalid", b_m_valid, 0);
    check("rst_c_s_tready", c_s_ready, 0);
    check("rst_a_modtimer", a_mt, 47);
    check("rst_a_underflow", a_uf, 0);
    check("rst_a_underflow_cnt", a_ufc, 0);
    check("rst_b_modtimer", b_mt, 0);
    check("rst_c_modtimer", c_mt, 11);

    // ---- Prime: one cycle with downstream not ready, so no slot is spent
    //      while the buffer is still empty ----
    rst = 1'b0;
    a_m_ready = 1'b0; b_m_ready = 1'b0; c_m_ready = 1'b0;
    tick();
    check("prime_a_modtimer", a_mt, 47);
    check("prime_a_tvalid", a_m_valid, 1);
    check("prime_a_tlast", a_m_last, 1);
    check("prime_a_tdata", a_m_data, 16'd0);
    a_m_ready = 1'b1; b_m_ready = 1'b1; c_m_ready = 1'b1;

    // ---- Default cadence: 47 (valid), 48..63 idle, 0..47 valid; stop at 10 ----
    exp_a = 47;
    for (int i = 0; i < 91; i++) begin
      tick();
      exp_a = (exp_a == 63) ? 0 : exp_a + 1;
      check("run_a_modtimer", a_mt, exp_a);
      check("run_a_tvalid", a_m_valid, exp_a < 48);
      check("run_a_tlast", a_m_last, exp_a == 47);
    end
    check("run_a_underflow", a_uf, 0);

    // ---- Backpressure: downstream stalls 5 cycles at modtimer 10 ----
    check("bp_a_s_tready_before", a_s_ready, 1);
    a_m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_a_modtimer", a_mt, 10);
      check("bp_a_tvalid", a_m_valid, 1);
      check("bp_a_tdata", a_m_data, a_exp);
      check("bp_a_s_tready", a_s_ready, 0);
    end
    a_m_ready = 1'b1;
    for (int i = 0; i < 59; i++) tick();
    check("bp_resume_a_modtimer", a_mt, 5);
    check("bp_resume_a_underflow_cnt", a_ufc, 0);

    // ---- Starvation: source idle during modtimer 5..7 ----
    a_s_valid = 1'b0;
    tick();
    check("starve_a_modtimer6", a_mt, 6);
    check("starve_a_tvalid6", a_m_valid, 0);
    check("starve_a_cnt6", a_ufc, 0);
    tick();
    check("starve_a_cnt7", a_ufc, 1);
    check("starve_a_underflow7", a_uf, 1);
    tick();
    check("starve_a_cnt8", a_ufc, 2);
    a_s_valid = 1'b1;
    tick();
    check("starve_a_modtimer9", a_mt, 9);
    check("starve_a_cnt9", a_ufc, 3);
    check("starve_a_underflow9", a_uf, 1);
    check("starve_a_tvalid9", a_m_valid, 1);
    check("starve_a_tdata9", a_m_data, a_exp);
    for (int i = 0; i < 60; i++) tick();
    check("wrap_a_modtimer", a_mt, 5);
    check("wrap_a_underflow_cnt", a_ufc, 3);

    // ---- Simultaneous push and pop with one entry ----
    check("pp_a_s_tready_before", a_s_ready, 1);
    check("pp_a_tvalid_before", a_m_valid, 1);
    tick();
    check("pp_a_modtimer", a_mt, 6);
    check("pp_a_s_tready_after", a_s_ready, 1);
    check("pp_a_tvalid_after", a_m_valid, 1);
    check("pp_a_tdata_after", a_m_data, a_exp);

    // ---- Reset mid-frame with the buffer full ----
    a_m_ready = 1'b0;
    tick();
    check("full_a_s_tready", a_s_ready, 0);
    check("full_a_modtimer", a_mt, 6);
    rst = 1'b1;
    #1;
    check("midrst_a_tvalid_during", a_m_valid, 0);
    check("midrst_a_tlast_during", a_m_last, 0);
    check("midrst_a_s_tready_during", a_s_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_a_modtimer", a_mt, 47);
    check("midrst_a_tvalid", a_m_valid, 0);
    check("midrst_a_s_tready", a_s_ready, 1);
    check("midrst_a_underflow", a_uf, 0);
    check("midrst_a_underflow_cnt", a_ufc, 0);
    // Buffered samples were discarded: the next word out is the next one accepted.
    a_exp = a_src; b_exp = b_src; c_exp = c_src;

    a_m_ready = 1'b0; b_m_ready = 1'b0; c_m_ready = 1'b0;
    tick();
    check("reprime_a_tvalid", a_m_valid, 1);
    check("reprime_a_tdata", a_m_data, a_exp);
    check("reprime_b_modtimer", b_mt, 0);
    check("reprime_b_tvalid", b_m_valid, 1);
    check("reprime_b_tlast", b_m_last, 0);
    check("reprime_c_modtimer", c_mt, 11);
    check("reprime_c_tvalid", c_m_valid, 1);
    check("reprime_c_tlast", c_m_last, 1);
    a_m_ready = 1'b1; b_m_ready = 1'b1; c_m_ready = 1'b1;

    // ---- Edge geometries: b continuous with tlast every 16; c 1 valid, 4 idle, 12 valid ----
    exp_b = 0;
    exp_c = 11;
    for (int i = 0; i < 34; i++) begin
      tick();
      exp_b = (exp_b == 15) ? 0 : exp_b + 1;
      exp_c = (exp_c == 15) ? 0 : exp_c + 1;
      check("edge_b_modtimer", b_mt, exp_b);
      check("edge_b_tvalid", b_m_valid, 1);
      check("edge_b_tlast", b_m_last, exp_b == 15);
      check("edge_c_modtimer", c_mt, exp_c);
      check("edge_c_tvalid", c_m_valid, exp_c < 12);
      check("edge_c_tlast", c_m_last, exp_c == 11);
    end
    check("end_a_underflow", a_uf, 0);
    check("end_b_underflow", b_uf, 0);
    check("end_c_underflow", c_uf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
